page_xfer_arbiter: RTL and testbench
====================================

PAGE_XFER_ARBITER -- requirements
Module: page_xfer_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of FIFO channels sharing the SDRAM page-command port.
REQ-002 Parameter CW, default 11: FIFO level width.
REQ-003 Parameter ROW_W, default 15: row address width.
REQ-004 Parameter WR_THRESH, default 512: write-channel level at or above which a page write is requested.
REQ-005 Parameter RD_THRESH, default 1024: read-channel level at or below which a page read is requested.
REQ-006 Parameter ACK_TMO, default 1023: cycles allowed for cmd_ack.
REQ-007 ti_clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 ch_en  in  NCH  per-channel enable.
REQ-010 ch_dir  in  NCH  1 = channel writes SDRAM (pipe-in FIFO); 0 = channel reads SDRAM (pipe-out FIFO).
REQ-011 ch_level  in  NCH*CW  channel FIFO fill level, channel i at [i*CW +: CW].
REQ-012 ch_base_row  in  NCH*ROW_W  first row of channel region.
REQ-013 ch_last_row  in  NCH*ROW_W  last row of channel region, inclusive.
REQ-014 cmd_pagewrite  out  1  page-write request to SDRAM controller.
REQ-015 cmd_pageread  out  1  page-read request to SDRAM controller.
REQ-016 cmd_ack  in  1  controller accepted command.
REQ-017 cmd_done  in  1  controller finished page.
REQ-018 rowaddr  out  ROW_W  row for current command.
REQ-019 grant_ch  out  clog2(NCH)  channel owning the port; valid while busy.
REQ-020 busy  out  1  high in REQ or XFER.
REQ-021 fault  out  NCH  sticky per-channel ack-timeout flag.
REQ-022 pages_done  out  32  total completed pages, wrapping.

Function
REQ-023 Channel i SHALL be eligible when ch_en[i] is high and either ch_dir[i]=1 with level >= WR_THRESH, or ch_dir[i]=0 with level <= RD_THRESH.
REQ-024 The FSM SHALL have states IDLE, REQ and XFER.
REQ-025 In IDLE with any eligible channel, the FSM SHALL register grant_ch round-robin, starting after the last granted channel, and enter REQ on the next cycle.
REQ-026 In REQ, cmd_pagewrite SHALL equal ch_dir[grant_ch] and cmd_pageread SHALL equal its inverse; both SHALL be 0 in every other state.
REQ-027 cmd_ack in REQ SHALL move the FSM to XFER next cycle and advance the granted channel's row pointer, wrapping from ch_last_row to ch_base_row.
REQ-028 rowaddr SHALL show the pre-increment pointer from REQ entry until XFER exit.
REQ-029 cmd_done in XFER SHALL return the FSM to IDLE and increment pages_done; cmd_done outside XFER SHALL be ignored.
REQ-030 cmd_ack and cmd_done asserted together in REQ SHALL be treated as ack only.
REQ-031 Deassertion of ch_en or a level change after grant SHALL NOT abort the command in flight.
REQ-032 IDLE SHALL last at least one cycle between commands.
REQ-033 The response from an eligible channel in IDLE to command assertion SHALL be 1 cycle.

Reset
REQ-034 On reset: state=IDLE, cmd_*=0, busy=0, grant_ch=0, fault=0, pages_done=0, RR pointer=NCH-1, and each row pointer loads ch_base_row.
REQ-035 A reset in REQ or XFER SHALL drop commands the same cycle and SHALL NOT count the page.

Configuration
REQ-036 Macro PXA_ACK_TIMEOUT_EN SHALL control the ack watchdog.
REQ-037 With PXA_ACK_TIMEOUT_EN defined: after ACK_TMO REQ cycles without ack, fault[grant_ch] is set, the FSM returns to IDLE, and the row pointer does not advance.
REQ-038 Without PXA_ACK_TIMEOUT_EN: REQ waits indefinitely and fault is tied to 0.

Structure
REQ-039 Package pxa_pkg SHALL hold the state enum and the default threshold and timeout constants.
REQ-040 Sub-module pxa_rr_pick SHALL implement the round-robin priority picker (request vector, last grant -> next grant, valid).

Verification
REQ-041 Bench SHALL cover: ch0 write, level 512, ack after 3 cycles, done after 600 cycles -> cmd_pagewrite high 3 cycles, rowaddr=base0, pages_done=1.
REQ-042 Bench SHALL cover: all 4 channels eligible, 8 commands -> grants 0,1,2,3,0,1,2,3.
REQ-043 Bench SHALL cover: base=10, last=12, 4 pages -> rowaddr 10,11,12,10.
REQ-044 Bench SHALL cover: read ch, level 1025 -> no request; level 1024 -> cmd_pageread.
REQ-045 Bench SHALL cover: timeout enabled, no ack for 1023 cycles -> fault[grant]=1, IDLE, row unchanged.
REQ-046 Bench SHALL cover: reset during XFER -> all outputs at reset values next cycle, pages_done=0.

Source files
------------

// File: rtl/pxa_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// pxa_pkg
// Shared definitions for the page transfer arbiter:
//   - pxa_state_t   : arbiter FSM states (IDLE, REQ, XFER)
//   - PXA_WR_THRESH : default write-channel level that triggers a page write
//   - PXA_RD_THRESH : default read-channel level that triggers a page read
//   - PXA_ACK_TMO   : default number of REQ cycles allowed before ack timeout
// ----------------------------------------------------------------------------
package pxa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } pxa_state_t;

    localparam int PXA_WR_THRESH = 512;
    localparam int PXA_RD_THRESH = 1024;
    localparam int PXA_ACK_TMO   = 1023;

endpackage

// File: rtl/pxa_rr_pick.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// pxa_rr_pick
// Combinational round-robin picker. The channel immediately after i_last has
// the highest priority, wrapping around; i_last itself has the lowest.
// Ports:
//   i_req   in  N  request vector, one bit per channel
//   i_last  in  W  most recently granted channel
//   o_grant out W  selected channel (0 when nothing requests)
//   o_valid out 1  at least one request present
// ----------------------------------------------------------------------------
module pxa_rr_pick #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_grant,
    output logic         o_valid
);

    int w_dist;
    int w_best;

    // Each requester gets a distance from the last grant; the smallest wins.
    // NOTE: combinational logic uses blocking '=' so each loop iteration sees
    // the best candidate found so far; clocked state uses '<=' only.
    always_comb begin
        // NOTE: every output and temporary is defaulted first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_valid = 1'b0;
        w_best  = N;
        w_dist  = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - 1 - int'(i_last)) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = W'(j);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/page_xfer_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// page_xfer_arbiter
// Shares one SDRAM page-command port between NCH FIFO channels. A write
// channel asks for a page once its FIFO holds at least WR_THRESH words; a read
// channel asks once its FIFO has drained to RD_THRESH words or fewer. Grants
// are round-robin; each channel walks its own row region, wrapping from its
// last row back to its base row.
//
// Optional feature: define PXA_ACK_TIMEOUT_EN to enable the ack watchdog.
// Without it REQ waits for cmd_ack indefinitely and fault is tied to 0.
//
// Ports:
//   ti_clk        in   1          clock, rising edge
//   reset         in   1          synchronous, active-high
//   ch_en         in   NCH        per-channel enable
//   ch_dir        in   NCH        1 = writes SDRAM, 0 = reads SDRAM
//   ch_level      in   NCH*CW     FIFO levels, channel i at [i*CW +: CW]
//   ch_base_row   in   NCH*ROW_W  first row of each channel region
//   ch_last_row   in   NCH*ROW_W  last row of each channel region (inclusive)
//   cmd_pagewrite out  1          page-write request
//   cmd_pageread  out  1          page-read request
//   cmd_ack       in   1          controller accepted the command
//   cmd_done      in   1          controller finished the page
//   rowaddr       out  ROW_W      row of the current command
//   grant_ch      out  clog2(NCH) channel owning the port
//   busy          out  1          high in REQ or XFER
//   fault         out  NCH        sticky per-channel ack-timeout flags
//   pages_done    out  32         completed page count, wrapping
// ----------------------------------------------------------------------------
module page_xfer_arbiter
    import pxa_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int CW        = 11,
    parameter  int ROW_W     = 15,
    parameter  int WR_THRESH = PXA_WR_THRESH,
    parameter  int RD_THRESH = PXA_RD_THRESH,
    parameter  int ACK_TMO   = PXA_ACK_TMO,
    localparam int GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 ti_clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       ch_dir,
    input  logic [NCH*CW-1:0]    ch_level,
    input  logic [NCH*ROW_W-1:0] ch_base_row,
    input  logic [NCH*ROW_W-1:0] ch_last_row,
    output logic                 cmd_pagewrite,
    output logic                 cmd_pageread,
    input  logic                 cmd_ack,
    input  logic                 cmd_done,
    output logic [ROW_W-1:0]     rowaddr,
    output logic [GW-1:0]        grant_ch,
    output logic                 busy,
    output logic [NCH-1:0]       fault,
    output logic [31:0]          pages_done
);

    pxa_state_t       r_state;
    logic             r_cmd_wr;
    logic             r_cmd_rd;
    logic             r_busy;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last;
    logic [ROW_W-1:0] r_rowaddr;
    logic [31:0]      r_pages;
    logic [ROW_W-1:0] r_row_ptr [NCH];

    logic [NCH-1:0]   w_elig;
    logic [GW-1:0]    w_pick;
    logic             w_pick_valid;
    logic [ROW_W-1:0] w_base [NCH];
    logic [ROW_W-1:0] w_last [NCH];
    logic [ROW_W-1:0] w_cur_row;
    logic [ROW_W-1:0] w_next_row;

`ifdef PXA_ACK_TIMEOUT_EN
    localparam int          TW       = $clog2(ACK_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);
    logic [TW-1:0]  r_tmo;
    logic [NCH-1:0] r_fault;
    assign fault = r_fault;
`else
    assign fault = '0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_rows
        assign w_base[g] = ch_base_row[g*ROW_W +: ROW_W];
        assign w_last[g] = ch_last_row[g*ROW_W +: ROW_W];
    end

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_dir[i])
                w_elig[i] = ch_en[i] && (32'(ch_level[i*CW +: CW]) >= 32'(WR_THRESH));
            else
                w_elig[i] = ch_en[i] && (32'(ch_level[i*CW +: CW]) <= 32'(RD_THRESH));
        end
    end

    pxa_rr_pick #(.N(NCH)) u_pick (
        .i_req   (w_elig),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Pointer advance for the granted channel, wrapping inside its region.
    assign w_cur_row  = r_row_ptr[r_grant];
    assign w_next_row = (w_cur_row == w_last[r_grant]) ? w_base[r_grant]
                                                        : w_cur_row + ROW_W'(1);

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cmd_wr  <= 1'b0;
            r_cmd_rd  <= 1'b0;
            r_busy    <= 1'b0;
            r_grant   <= '0;
            r_last    <= GW'(NCH - 1);
            r_rowaddr <= '0;
            r_pages   <= '0;
            // NOTE: the row pointer array is reset deliberately: every channel
            // must restart its page walk at its own base row.
            for (int i = 0; i < NCH; i++) r_row_ptr[i] <= w_base[i];
`ifdef PXA_ACK_TIMEOUT_EN
            r_tmo     <= '0;
            r_fault   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Direction and row are captured here so later changes on
                    // the channel inputs cannot disturb the command in flight.
                    if (w_pick_valid) begin
                        r_state   <= ST_REQ;
                        r_grant   <= w_pick;
                        r_last    <= w_pick;
                        r_rowaddr <= r_row_ptr[w_pick];
                        r_cmd_wr  <= ch_dir[w_pick];
                        r_cmd_rd  <= ~ch_dir[w_pick];
                        r_busy    <= 1'b1;
`ifdef PXA_ACK_TIMEOUT_EN
                        r_tmo     <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    // cmd_done is not looked at here, so ack+done is ack only.
                    if (cmd_ack) begin
                        r_state            <= ST_XFER;
                        r_cmd_wr           <= 1'b0;
                        r_cmd_rd           <= 1'b0;
                        r_row_ptr[r_grant] <= w_next_row;
                    end
`ifdef PXA_ACK_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_state          <= ST_IDLE;
                        r_cmd_wr         <= 1'b0;
                        r_cmd_rd         <= 1'b0;
                        r_busy           <= 1'b0;
                        r_fault[r_grant] <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
`endif
                end
                ST_XFER: begin
                    if (cmd_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_pages <= r_pages + 32'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cmd_wr <= 1'b0;
                    r_cmd_rd <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Commands are masked by reset directly so they drop in the reset cycle.
    assign cmd_pagewrite = r_cmd_wr & ~reset;
    assign cmd_pageread  = r_cmd_rd & ~reset;
    assign rowaddr       = r_rowaddr;
    assign grant_ch      = r_grant;
    assign busy          = r_busy;
    assign pages_done    = r_pages;

endmodule

// File: tb/tb_page_xfer_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_page_xfer_arbiter
// Directed bench for page_xfer_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_page_xfer_arbiter;

    localparam int NCH   = 4;
    localparam int CW    = 11;
    localparam int ROW_W = 15;

    logic                 ti_clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       ch_dir;
    logic [NCH*CW-1:0]    ch_level;
    logic [NCH*ROW_W-1:0] ch_base_row;
    logic [NCH*ROW_W-1:0] ch_last_row;
    logic                 cmd_pagewrite;
    logic                 cmd_pageread;
    logic                 cmd_ack;
    logic                 cmd_done;
    logic [ROW_W-1:0]     rowaddr;
    logic [1:0]           grant_ch;
    logic                 busy;
    logic [NCH-1:0]       fault;
    logic [31:0]          pages_done;

    int n_vec  = 0;
    int n_miss = 0;

    page_xfer_arbiter dut (
        .ti_clk        (ti_clk),
        .reset         (reset),
        .ch_en         (ch_en),
        .ch_dir        (ch_dir),
        .ch_level      (ch_level),
        .ch_base_row   (ch_base_row),
        .ch_last_row   (ch_last_row),
        .cmd_pagewrite (cmd_pagewrite),
        .cmd_pageread  (cmd_pageread),
        .cmd_ack       (cmd_ack),
        .cmd_done      (cmd_done),
        .rowaddr       (rowaddr),
        .grant_ch      (grant_ch),
        .busy          (busy),
        .fault         (fault),
        .pages_done    (pages_done)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic tick();
        @(negedge ti_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_level(input int ch, input int lvl);
        ch_level[ch*CW +: CW] = CW'(lvl);
    endtask

    task automatic set_rows(input int ch, input int base, input int last);
        ch_base_row[ch*ROW_W +: ROW_W] = ROW_W'(base);
        ch_last_row[ch*ROW_W +: ROW_W] = ROW_W'(last);
    endtask

    // Bounded wait for a command to appear.
    task automatic wait_cmd(input string tag);
        int k;
        k = 0;
        while (!(cmd_pagewrite || cmd_pageread) && k < 40) begin
            tick();
            k++;
        end
        check({tag, " cmd_arrive"}, 32'(cmd_pagewrite | cmd_pageread), 1);
    endtask

    // Ack in the current REQ cycle, then done in the first XFER cycle.
    task automatic finish_cmd(input string tag);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check({tag, " xfer_busy"}, 32'(busy), 1);
        check({tag, " xfer_cmd"}, 32'(cmd_pagewrite | cmd_pageread), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check({tag, " idle_busy"}, 32'(busy), 0);
    endtask

    task automatic run_cmd(input string tag, input int g, input int row, input logic wr);
        wait_cmd(tag);
        check({tag, " grant"}, 32'(grant_ch), g);
        check({tag, " row"}, 32'(rowaddr), row);
        check({tag, " pw"}, 32'(cmd_pagewrite), 32'(wr));
        check({tag, " pr"}, 32'(cmd_pageread), 32'(!wr));
        finish_cmd(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish by time limit, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int g_exp [8];
        int r_exp [8];
        g_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        r_exp = '{100, 200, 10, 300, 101, 201, 11, 301};

        reset       = 1'b1;
        ch_en       = '0;
        ch_dir      = '0;
        ch_level    = '0;
        ch_base_row = '0;
        ch_last_row = '0;
        cmd_ack     = 1'b0;
        cmd_done    = 1'b0;
        set_rows(0, 100, 103);
        set_rows(1, 200, 203);
        set_rows(2, 10, 12);
        set_rows(3, 300, 303);
        for (int i = 0; i < NCH; i++) set_level(i, 600);

        // Reset state
        tick();
        check("rst pw", 32'(cmd_pagewrite), 0);
        check("rst pr", 32'(cmd_pageread), 0);
        check("rst busy", 32'(busy), 0);
        check("rst grant", 32'(grant_ch), 0);
        check("rst fault", 32'(fault), 0);
        check("rst pages", pages_done, 0);
        reset = 1'b0;

        // Channel 0 write at exactly the write threshold, ack after 3 cycles
        ch_en  = 4'b0001;
        ch_dir = 4'b0001;
        set_level(0, 512);
        tick();
        check("t1 pw c1", 32'(cmd_pagewrite), 1);
        check("t1 pr", 32'(cmd_pageread), 0);
        check("t1 grant", 32'(grant_ch), 0);
        check("t1 row", 32'(rowaddr), 100);
        check("t1 busy", 32'(busy), 1);
        ch_en    = 4'b0000;        // must not abort
        set_level(0, 0);
        cmd_done = 1'b1;           // ignored outside XFER
        tick();
        check("t1 pw c2", 32'(cmd_pagewrite), 1);
        cmd_done = 1'b0;
        tick();
        check("t1 pw c3", 32'(cmd_pagewrite), 1);
        cmd_ack  = 1'b1;
        cmd_done = 1'b1;           // together with ack: ack only
        tick();
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        check("t1 pw c4", 32'(cmd_pagewrite), 0);
        check("t1 xfer busy", 32'(busy), 1);
        check("t1 xfer pages", pages_done, 0);
        check("t1 xfer row", 32'(rowaddr), 100);
        repeat (599) tick();
        check("t1 xfer hold", 32'(busy), 1);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("t1 done busy", 32'(busy), 0);
        check("t1 done pages", pages_done, 1);

        // Round robin across four eligible write channels
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ch_dir = 4'b1111;
        for (int i = 0; i < NCH; i++) set_level(i, 600);
        ch_en  = 4'b1111;
        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("t2 cmd%0d", i), g_exp[i], r_exp[i], 1'b1);
        ch_en = 4'b0000;
        check("t2 pages", pages_done, 8);

        // Row wrap: base 10, last 12
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ch_en = 4'b0100;
        run_cmd("t3 p0", 2, 10, 1'b1);
        run_cmd("t3 p1", 2, 11, 1'b1);
        run_cmd("t3 p2", 2, 12, 1'b1);
        run_cmd("t3 p3", 2, 10, 1'b1);
        ch_en = 4'b0000;
        check("t3 pages", pages_done, 4);

        // Read threshold boundary on channel 1
        ch_dir = 4'b0000;
        set_level(1, 1025);
        ch_en  = 4'b0010;
        tick();
        check("t4 above busy", 32'(busy), 0);
        repeat (4) tick();
        check("t4 above pr", 32'(cmd_pageread), 0);
        check("t4 above busy2", 32'(busy), 0);
        set_level(1, 1024);
        tick();
        check("t4 pr", 32'(cmd_pageread), 1);
        check("t4 pw", 32'(cmd_pagewrite), 0);
        check("t4 grant", 32'(grant_ch), 1);
        check("t4 row", 32'(rowaddr), 200);
        finish_cmd("t4");
        ch_en = 4'b0000;
        cmd_done = 1'b1;           // done while IDLE is ignored
        tick();
        cmd_done = 1'b0;
        tick();
        check("t4 idle done", pages_done, 5);

        // Ack watchdog on channel 3
        ch_dir = 4'b1111;
        set_level(3, 600);
        ch_en  = 4'b1000;
        wait_cmd("t5");
        check("t5 grant", 32'(grant_ch), 3);
        check("t5 row", 32'(rowaddr), 300);
        repeat (1022) tick();
        check("t5 last req", 32'(cmd_pagewrite), 1);
        tick();
`ifdef PXA_ACK_TIMEOUT_EN
        check("t5 tmo busy", 32'(busy), 0);
        check("t5 tmo pw", 32'(cmd_pagewrite), 0);
        check("t5 tmo fault", 32'(fault), 32'h8);
        ch_en = 4'b0000;
        tick();
        check("t5 tmo idle", 32'(busy), 0);
        ch_en = 4'b1000;
        run_cmd("t5 retry", 3, 300, 1'b1);
        ch_en = 4'b0000;
        check("t5 fault sticky", 32'(fault), 32'h8);
`else
        check("t5 wait busy", 32'(busy), 1);
        check("t5 wait pw", 32'(cmd_pagewrite), 1);
        check("t5 wait fault", 32'(fault), 0);
        finish_cmd("t5");
        ch_en = 4'b0000;
        check("t5 fault", 32'(fault), 0);
`endif
        check("t5 pages", pages_done, 6);

        // Reset in REQ drops the command in the same cycle
        set_level(0, 600);
        ch_en = 4'b0001;
        wait_cmd("t6a");
        reset = 1'b1;
        ch_en = 4'b0000;
        #1;
        check("t6 drop pw", 32'(cmd_pagewrite), 0);
        tick();
        reset = 1'b0;
        check("t6a busy", 32'(busy), 0);

        // Reset in XFER, with done in the same cycle: page not counted
        set_level(1, 1024);
        ch_en = 4'b0010;
        wait_cmd("t6b");
        check("t6b grant", 32'(grant_ch), 1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("t6b xfer", 32'(busy), 1);
        reset    = 1'b1;
        cmd_done = 1'b1;
        ch_en    = 4'b0000;
        tick();
        reset    = 1'b0;
        cmd_done = 1'b0;
        check("t6 rst pw", 32'(cmd_pagewrite), 0);
        check("t6 rst pr", 32'(cmd_pageread), 0);
        check("t6 rst busy", 32'(busy), 0);
        check("t6 rst grant", 32'(grant_ch), 0);
        check("t6 rst fault", 32'(fault), 0);
        check("t6 rst pages", pages_done, 0);
        check("t6 rst row", 32'(rowaddr), 0);

        // Row pointers reload from base on reset
        ch_en = 4'b0001;
        tick();
        check("t7 row reload", 32'(rowaddr), 100);
        check("t7 grant", 32'(grant_ch), 0);
        finish_cmd("t7");
        ch_en = 4'b0000;
        check("t7 pages", pages_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
